// File: rtl/wbu.sv
// wbu: write-back and PC-update unit for the NPC core.
// Takes one resolved instruction at a time from execute, runs any load/store
// on the data-memory port, writes the register file and hands the next PC to
// fetch. It is the sole owner of the architectural PC.
module wbu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_alu_result,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_wen,
  input  logic        ex_link,
  input  logic        ex_mem_ren,
  input  logic        ex_mem_wen,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_mem_unsigned,
  input  logic [31:0] ex_store_data,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        rf_wen,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] pc,
  output logic        pc_valid,
  input  logic        pc_ready,
  output logic        misalign
);

  typedef enum logic [2:0] {NOTIFY, IDLE, REQ, RESP, COMMIT} state_t;

  state_t      state;
  logic [31:0] ex_pc_p1, alu_p1, tgt_p1, sdata_p1, ld_data_p1;
  logic        taken_p1, link_p1, reg_wen_p1, ren_p1, swen_p1, uns_p1, mis_p1;
  logic [1:0]  size_p1;
  logic [4:0]  rd_p1;
  logic        mis_now;
  logic        commit;

  // Shift the addressed lane down, then sign- or zero-extend byte/half.
  function automatic logic [31:0] load_extract(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic        uns);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = rdata >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'd0:    load_extract = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'd1:    load_extract = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: load_extract = rdata;
    endcase
  endfunction

  // Replicate the store value across every lane it could land in.
  function automatic logic [31:0] store_lanes(input logic [31:0] d,
                                              input logic [1:0]  size);
    case (size)
      2'd0:    store_lanes = {4{d[7:0]}};
      2'd1:    store_lanes = {2{d[15:0]}};
      default: store_lanes = d;
    endcase
  endfunction

  // Byte enables for the addressed lane(s).
  function automatic logic [3:0] store_strb(input logic [1:0] off,
                                            input logic [1:0] size);
    case (size)
      2'd0:    store_strb = 4'b0001 << off;
      2'd1:    store_strb = off[1] ? 4'b1100 : 4'b0011;
      default: store_strb = 4'b1111;
    endcase
  endfunction

  // Alignment check on the incoming instruction; bytes are always aligned.
  always_comb begin
    mis_now = (ex_mem_ren || ex_mem_wen) &&
              (((ex_mem_size == 2'd1) && ex_alu_result[0]) ||
               (ex_mem_size[1] && (ex_alu_result[1:0] != 2'b00)));
  end

  // Moore outputs decoded from state and the latched instruction.
  always_comb begin
    commit        = (state == COMMIT);
    ex_ready      = (state == IDLE);
    pc_valid      = (state == NOTIFY);
    mem_req_valid = (state == REQ);
    mem_req_addr  = {alu_p1[31:2], 2'b00};
    mem_req_wen   = swen_p1;
    mem_req_wdata = store_lanes(sdata_p1, size_p1);
    mem_req_wstrb = swen_p1 ? store_strb(alu_p1[1:0], size_p1) : 4'b0000;
    rf_wen        = commit && reg_wen_p1 && (rd_p1 != 5'd0) && !mis_p1;
    misalign      = commit && mis_p1;
    rf_waddr      = commit ? rd_p1 : 5'd0;
    rf_wdata      = 32'd0;
    if (commit) begin
      if (link_p1)     rf_wdata = ex_pc_p1 + 32'd4;
      else if (ren_p1) rf_wdata = ld_data_p1;
      else             rf_wdata = alu_p1;
    end
  end

  // Control FSM and architectural PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= NOTIFY;
      pc    <= RESET_PC;
    end else begin
      case (state)
        NOTIFY: if (pc_ready) state <= IDLE;
        IDLE: begin
          if (ex_valid) begin
            if (mis_now)                        state <= COMMIT;
            else if (ex_mem_ren || ex_mem_wen)  state <= REQ;
            else                                state <= COMMIT;
          end
        end
        REQ:    if (mem_req_ready) state <= swen_p1 ? COMMIT : RESP;
        RESP:   if (mem_resp_valid) state <= COMMIT;
        COMMIT: begin
          pc    <= taken_p1 ? tgt_p1 : ex_pc_p1 + 32'd4;
          state <= NOTIFY;
        end
        default: state <= NOTIFY;
      endcase
    end
  end

  // Stage p1: capture the accepted instruction and the extracted load data.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && ex_valid) begin
      ex_pc_p1   <= ex_pc;
      alu_p1     <= ex_alu_result;
      tgt_p1     <= ex_branch_target;
      sdata_p1   <= ex_store_data;
      taken_p1   <= ex_branch_taken;
      link_p1    <= ex_link;
      reg_wen_p1 <= ex_reg_wen;
      ren_p1     <= ex_mem_ren;
      swen_p1    <= ex_mem_wen;
      uns_p1     <= ex_mem_unsigned;
      size_p1    <= ex_mem_size;
      rd_p1      <= ex_rd;
      mis_p1     <= mis_now;
    end
    if ((state == RESP) && mem_resp_valid)
      ld_data_p1 <= load_extract(mem_resp_rdata, alu_p1[1:0], size_p1, uns_p1);
  end

endmodule

// File: tb/tb_wbu.sv
// Directed bench for wbu: each instruction pushes its expected commit onto a
// scoreboard queue, a small memory responder serves the request, and the
// commit observed just before pc_valid returns is popped and compared.
module tb_wbu;
  logic        clk = 1'b0;
  logic        rst, ex_valid, ex_ready;
  logic [31:0] ex_pc, ex_alu_result, ex_branch_target, ex_store_data;
  logic        ex_branch_taken, ex_reg_wen, ex_link, ex_mem_ren, ex_mem_wen, ex_mem_unsigned;
  logic [4:0]  ex_rd;
  logic [1:0]  ex_mem_size;
  logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
  logic [3:0]  mem_req_wstrb;
  logic        rf_wen, pc_valid, pc_ready, misalign;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, pc;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        mis;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  wbu dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
    .ex_alu_result(ex_alu_result), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen),
    .ex_link(ex_link), .ex_mem_ren(ex_mem_ren), .ex_mem_wen(ex_mem_wen),
    .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned),
    .ex_store_data(ex_store_data), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc), .pc_valid(pc_valid),
    .pc_ready(pc_ready), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_c(input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                          input logic mis, input logic [31:0] npc);
    exp_t e;
    e.wen = wen; e.waddr = waddr; e.wdata = wdata; e.mis = mis; e.pc = npc;
    sb.push_back(e);
  endtask

  task automatic set_ex(input logic [31:0] p, input logic [31:0] alu, input logic taken,
                        input logic [31:0] tgt, input logic [4:0] rd, input logic wen,
                        input logic link, input logic ren, input logic swen,
                        input logic [1:0] size, input logic uns, input logic [31:0] sdata);
    ex_pc = p; ex_alu_result = alu; ex_branch_taken = taken; ex_branch_target = tgt;
    ex_rd = rd; ex_reg_wen = wen; ex_link = link; ex_mem_ren = ren; ex_mem_wen = swen;
    ex_mem_size = size; ex_mem_unsigned = uns; ex_store_data = sdata;
  endtask

  // Called at a negedge while the unit is idle; handshake on the next posedge.
  task automatic fire();
    chk("ex_ready_before_hs", 32'(ex_ready), 32'd1);
    ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  task automatic issue(input int req_wait, input int resp_wait, input logic [31:0] rdata,
                       input logic exp_req, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wdata, input logic [3:0] exp_strb);
    exp_t        e;
    logic        done, saw_req, resp_pend, l_wen, l_mis;
    logic [4:0]  l_waddr;
    logic [31:0] l_wdata;
    int          rq, rw;
    done = 0; saw_req = 0; resp_pend = 0; rq = 0; rw = 0;
    l_wen = 0; l_mis = 0; l_waddr = 0; l_wdata = 0;
    fire();
    for (int c = 0; c < 40 && !done; c++) begin
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0;
      if (pc_valid) done = 1;
      else begin
        l_wen = rf_wen; l_mis = misalign; l_waddr = rf_waddr; l_wdata = rf_wdata;
        if (mem_req_valid) begin
          saw_req = 1;
          chk("req_addr", mem_req_addr, exp_addr);
          chk("req_wen", 32'(mem_req_wen), 32'(ex_mem_wen));
          chk("req_wstrb", 32'(mem_req_wstrb), 32'(exp_strb));
          if (ex_mem_wen) chk("req_wdata", mem_req_wdata, exp_wdata);
          if (rq >= req_wait) begin
            mem_req_ready = 1'b1;
            resp_pend = ex_mem_ren;
          end
          rq++;
        end else if (resp_pend) begin
          if (rw >= resp_wait) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = rdata;
            resp_pend = 0;
          end
          rw++;
        end
        @(negedge clk);
      end
    end
    if (!done) chk("commit_timeout", 32'd0, 32'd1);
    if (sb.size() == 0) chk("sb_empty", 32'd0, 32'd1);
    else begin
      e = sb.pop_front();
      chk("rf_wen", 32'(l_wen), 32'(e.wen));
      chk("misalign", 32'(l_mis), 32'(e.mis));
      if (e.wen) begin
        chk("rf_waddr", 32'(l_waddr), 32'(e.waddr));
        chk("rf_wdata", l_wdata, e.wdata);
      end
      chk("pc", pc, e.pc);
    end
    chk("req_seen", 32'(saw_req), 32'(exp_req));
    pc_ready = 1'b1;
    @(negedge clk);
    pc_ready = 1'b0;
    chk("ex_ready_idle", 32'(ex_ready), 32'd1);
    chk("pc_valid_idle", 32'(pc_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; pc_ready = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = 32'd0;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_pc", pc, 32'h8000_0000);
    chk("rst_pc_valid", 32'(pc_valid), 32'd1);
    chk("rst_ex_ready", 32'(ex_ready), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_rf_wen", 32'(rf_wen), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    pc_ready = 1'b1;
    @(negedge clk);
    pc_ready = 1'b0;
    chk("idle_ex_ready", 32'(ex_ready), 32'd1);

    // ADDI rd=5, then rd=0
    set_ex(32'h8000_0000, 32'h15, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    expect_c(1, 5, 32'h15, 0, 32'h8000_0004);
    issue(0, 0, 0, 0, 0, 0, 0);
    set_ex(32'h8000_0004, 32'h7, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    expect_c(0, 0, 0, 0, 32'h8000_0008);
    issue(0, 0, 0, 0, 0, 0, 0);
    // JAL
    set_ex(32'h8000_0010, 32'h8000_0100, 1, 32'h8000_0100, 1, 1, 1, 0, 0, 0, 0, 0);
    expect_c(1, 1, 32'h8000_0014, 0, 32'h8000_0100);
    issue(0, 0, 0, 0, 0, 0, 0);
    // LB / LBU at lane 3, 3 response wait cycles
    set_ex(32'h8000_0020, 32'h8000_0203, 0, 0, 6, 1, 0, 1, 0, 0, 0, 0);
    expect_c(1, 6, 32'hFFFF_FF80, 0, 32'h8000_0024);
    issue(0, 3, 32'h80FF_FF7F, 1, 32'h8000_0200, 0, 4'b0000);
    set_ex(32'h8000_0024, 32'h8000_0203, 0, 0, 7, 1, 0, 1, 0, 0, 1, 0);
    expect_c(1, 7, 32'h0000_0080, 0, 32'h8000_0028);
    issue(0, 3, 32'h80FF_FF7F, 1, 32'h8000_0200, 0, 4'b0000);
    // LH upper half, LHU lower half, LW
    set_ex(32'h8000_0028, 32'h8000_0202, 0, 0, 8, 1, 0, 1, 0, 1, 0, 0);
    expect_c(1, 8, 32'hFFFF_8001, 0, 32'h8000_002C);
    issue(1, 0, 32'h8001_1234, 1, 32'h8000_0200, 0, 4'b0000);
    set_ex(32'h8000_002C, 32'h8000_0200, 0, 0, 9, 1, 0, 1, 0, 1, 1, 0);
    expect_c(1, 9, 32'h0000_1234, 0, 32'h8000_0030);
    issue(0, 1, 32'h8001_1234, 1, 32'h8000_0200, 0, 4'b0000);
    set_ex(32'h8000_0030, 32'h8000_0300, 0, 0, 10, 1, 0, 1, 0, 2, 0, 0);
    expect_c(1, 10, 32'hDEAD_BEEF, 0, 32'h8000_0034);
    issue(0, 0, 32'hDEAD_BEEF, 1, 32'h8000_0300, 0, 4'b0000);
    // SH upper half with 2 request wait cycles, SB lane 1, SW
    set_ex(32'h8000_0034, 32'h8000_0102, 0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h1234_ABCD);
    expect_c(0, 0, 0, 0, 32'h8000_0038);
    issue(2, 0, 0, 1, 32'h8000_0100, 32'hABCD_ABCD, 4'b1100);
    set_ex(32'h8000_0038, 32'h8000_0101, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0000_0055);
    expect_c(0, 0, 0, 0, 32'h8000_003C);
    issue(0, 0, 0, 1, 32'h8000_0100, 32'h5555_5555, 4'b0010);
    set_ex(32'h8000_003C, 32'h8000_0104, 0, 0, 0, 0, 0, 0, 1, 2, 0, 32'hCAFE_F00D);
    expect_c(0, 0, 0, 0, 32'h8000_0040);
    issue(1, 0, 0, 1, 32'h8000_0104, 32'hCAFE_F00D, 4'b1111);
    // Misaligned SW and LH: dropped, misalign pulse, no request, no rf write
    set_ex(32'h8000_0040, 32'h8000_0101, 0, 0, 0, 0, 0, 0, 1, 2, 0, 32'h1111_2222);
    expect_c(0, 0, 0, 1, 32'h8000_0044);
    issue(0, 0, 0, 0, 0, 0, 0);
    set_ex(32'h8000_0044, 32'h8000_0001, 0, 0, 3, 1, 0, 1, 0, 1, 0, 0);
    expect_c(0, 0, 0, 1, 32'h8000_0048);
    issue(0, 0, 0, 0, 0, 0, 0);
    // Taken branch without link, then pc+4 wrap
    set_ex(32'h8000_0050, 32'h0, 1, 32'h8000_0200, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_c(0, 0, 0, 0, 32'h8000_0200);
    issue(0, 0, 0, 0, 0, 0, 0);
    set_ex(32'hFFFF_FFFC, 32'h1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0);
    expect_c(1, 4, 32'h1, 0, 32'h0000_0000);
    issue(0, 0, 0, 0, 0, 0, 0);

    // Reset while waiting in RESP, then a late response pulse
    set_ex(32'h8000_0400, 32'h8000_0400, 0, 0, 11, 1, 0, 1, 0, 2, 0, 0);
    fire();
    chk("rr_req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1234_5678;
    chk("rr_pc", pc, 32'h8000_0000);
    chk("rr_pc_valid", 32'(pc_valid), 32'd1);
    chk("rr_ex_ready", 32'(ex_ready), 32'd0);
    chk("rr_rf_wen", 32'(rf_wen), 32'd0);
    chk("rr_req_valid_after", 32'(mem_req_valid), 32'd0);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("rr_rf_wen_late", 32'(rf_wen), 32'd0);
    chk("rr_pc_valid_late", 32'(pc_valid), 32'd1);
    pc_ready = 1'b1;
    @(negedge clk);
    pc_ready = 1'b0;
    set_ex(32'h8000_0000, 32'h42, 0, 0, 12, 1, 0, 0, 0, 0, 0, 0);
    expect_c(1, 12, 32'h42, 0, 32'h8000_0004);
    issue(0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wbu.md
# wbu

Write-back and PC-update unit for the NPC core, sitting directly downstream of the execute stage. It accepts one resolved instruction at a time from the execute stage and performs any load/store on the data-memory port. It then writes the register file and commits the next PC, which it offers to the fetch stage through a valid/ready handshake. It is the only owner of the architectural PC register.

## Interface
- RESET_PC, 32'h8000_0000, PC value loaded on reset and offered first to fetch
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  execute result valid
- ex_ready  out  1  unit can accept a result (handshake when ex_valid && ex_ready)
- ex_pc  in  32  PC of the instruction
- ex_alu_result  in  32  ALU result / memory effective address
- ex_branch_taken  in  1  redirect PC to ex_branch_target
- ex_branch_target  in  32  redirect target
- ex_rd  in  5  destination register
- ex_reg_wen  in  1  instruction writes rd
- ex_link  in  1  JAL/JALR: rd gets ex_pc+4
- ex_mem_ren / ex_mem_wen  in  1/1  load / store (never both)
- ex_mem_size  in  2  0=byte, 1=half, 2=word
- ex_mem_unsigned  in  1  zero-extend load (LBU/LHU)
- ex_store_data  in  32  rs2 value for stores
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_req_wen  out  1  1=write
- mem_req_wdata  out  32  store data, lane-replicated
- mem_req_wstrb  out  4  byte enables (0 for reads)
- mem_resp_valid  in  1  read data valid
- mem_resp_rdata  in  32  aligned read word
- rf_wen  out  1  register-file write pulse
- rf_waddr  out  5  write address
- rf_wdata  out  32  write data
- pc  out  32  architectural PC
- pc_valid  out  1  pc is the next fetch address
- pc_ready  in  1  fetch accepted pc
- misalign  out  1  one-cycle pulse: misaligned access dropped

## Operation
- FSM states: NOTIFY, IDLE, REQ, RESP, COMMIT. All outputs are registered or decoded from state (Moore).
- NOTIFY: pc_valid=1. On pc_ready, go to IDLE.
- IDLE: ex_ready=1. On handshake, latch all ex_* inputs.
  - Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0): go to COMMIT with rf write suppressed and misalign pulsed in COMMIT.
  - Otherwise load/store goes to REQ, everything else goes to COMMIT.
- REQ: mem_req_valid=1, with fields held stable until mem_req_ready. On accept, a store goes to COMMIT and a load goes to RESP.
- RESP: wait for mem_resp_valid, ignoring it in every other state. Then latch the extracted data and go to COMMIT.
- Load extraction: shift rdata right by 8*addr[1:0], take the low byte or half, then sign-extend (or zero-extend if ex_mem_unsigned). Word loads pass through unchanged.
- Store lanes:
  - byte: wdata={4{b}}, wstrb=1<<addr[1:0]
  - half: wdata={2{h}}, wstrb=addr[1]?4'b1100:4'b0011
  - word: wstrb=4'b1111
- COMMIT (exactly one cycle):
  - rf_wen=ex_reg_wen && rd!=0 && !misalign.
  - rf_wdata selects ex_pc+4 if link, else load data if load, else ex_alu_result.
  - pc <= taken ? target : ex_pc+4. The lowest bit is not modified; the execute stage already clears it for JALR.
  - Go to NOTIFY.
- Arithmetic is 32-bit modulo; pc+4 wraps at 2^32.
- Reset (any state, including mid-REQ/RESP):
  - State goes to NOTIFY and pc=RESET_PC.
  - rf_wen=0, mem_req_valid=0, misalign=0, ex_ready=0, pc_valid=1 in the first cycle after rst deasserts.
  - An outstanding memory request is abandoned and a late mem_resp_valid is ignored.

## Timing
- Reset values: pc=RESET_PC, pc_valid=1 (after rst low), ex_ready=0, mem_req_valid=0, rf_wen=0, misalign=0, rf_waddr/rf_wdata=0.
- Non-memory instruction: handshake in cycle N, COMMIT in N+1, pc_valid with the new pc in N+2. Throughput is one instruction per 3 cycles with pc_ready=1.
- Load with zero-wait memory: accept N, REQ N+1, RESP N+2 (resp may arrive here at the earliest), COMMIT N+3, NOTIFY N+4. Each wait cycle on mem_req_ready or mem_resp_valid adds one cycle.
- The memory must not assert mem_resp_valid for a request before accepting it.
- ex_ready and pc_valid are never high together; ex_valid held across non-IDLE states is not consumed.

## Test plan
- Reset: rst high 2 cycles then low -> pc=0x8000_0000, pc_valid=1, ex_ready=0. pc_ready=1 -> IDLE, ex_ready=1.
- ADDI: ex_pc=0x8000_0000, alu=0x15, rd=5 -> COMMIT: rf_wen=1, waddr=5, wdata=0x15. Next cycle pc=0x8000_0004, pc_valid=1. rd=0 -> rf_wen=0.
- JAL: ex_pc=0x8000_0010, taken=1, target=0x8000_0100, link=1, rd=1 -> wdata=0x8000_0014, pc=0x8000_0100.
- LB signed: addr=0x8000_0203, rdata=0x80FF_FF7F, 3 wait cycles on mem_resp_valid -> mem_req_addr=0x8000_0200, wdata=0xFFFF_FF80. With LBU -> 0x0000_0080.
- SH: addr=0x8000_0102, data=0x1234_ABCD, mem_req_ready low 2 cycles -> req fields stable, wdata=0xABCD_ABCD, wstrb=4'b1100, rf_wen=0. Misaligned SW at 0x...01 -> misalign pulse, no mem_req_valid.
- Reset during RESP: rst in RESP cycle, then mem_resp_valid pulses -> no rf_wen, pc=RESET_PC, pc_valid=1.
